// File: rtl/interrupt_sequencer_if.sv
// Handshake bundle between the interrupt controller / pipeline side and the sequencer.
// master = interrupt controller and pipeline side; slave = sequencer.
interface interrupt_sequencer_if #(
    parameter int PC_WIDTH = 32
);
    logic                int_req;
    logic [2:0]          int_level;
    logic [PC_WIDTH-1:0] pc_current;
    logic                pipe_empty;
    logic                eret;
    logic                stall;
    logic                pc_load;
    logic [PC_WIDTH-1:0] pc_target;
    logic                int_end;
    logic [1:0]          depth;
    logic                err;

    modport master (
        output int_req, int_level, pc_current, pipe_empty, eret,
        input  stall, pc_load, pc_target, int_end, depth, err
    );

    modport slave (
        input  int_req, int_level, pc_current, pipe_empty, eret,
        output stall, pc_load, pc_target, int_end, depth, err
    );
endinterface

// File: rtl/interrupt_sequencer.sv
// Interrupt entry/exit sequencer: drain, push resume PC, vector; on ERET pop and return.
// Entry: stall N+1, pc_load N+2. ERET: pc_load/int_end N+1. Macro INTSEQ_ERR_EN enables sticky err.
module interrupt_sequencer #(
    parameter int                  PC_WIDTH      = 32,
    parameter int                  DEPTH         = 3,
    parameter logic [PC_WIDTH-1:0] VECTOR_BASE   = PC_WIDTH'(32'h0000_0100),
    parameter logic [PC_WIDTH-1:0] VECTOR_STRIDE = PC_WIDTH'(32'h0000_0010)
) (
    input  logic                  clock,
    input  logic                  reset,
    interrupt_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, DRAIN, VEC, RET} state_t;

    state_t              state_q, state_d;
    logic                stall_q, stall_d;
    logic                pc_load_q, pc_load_d;
    logic                int_end_q, int_end_d;
    logic [PC_WIDTH-1:0] pc_target_q, pc_target_d;
    logic [1:0]          depth_q, depth_d;
    logic                pending_q, pending_d;
    logic                push;
    logic [PC_WIDTH-1:0] stack_q [DEPTH];
    logic [PC_WIDTH-1:0] top_entry;
    logic [PC_WIDTH-1:0] vec_addr;

    always_comb begin
        top_entry = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (depth_q == 2'(i + 1)) top_entry = stack_q[i];
        end
    end

    // Highest active level wins when several bits are set.
    always_comb begin
        vec_addr = VECTOR_BASE;
        if (bus.int_level[2])      vec_addr = VECTOR_BASE + (VECTOR_STRIDE << 1);
        else if (bus.int_level[1]) vec_addr = VECTOR_BASE + VECTOR_STRIDE;
    end

    always_comb begin
        state_d     = state_q;
        stall_d     = stall_q;
        pc_load_d   = 1'b0;
        int_end_d   = 1'b0;
        pc_target_d = pc_target_q;
        depth_d     = depth_q;
        pending_d   = pending_q | bus.int_req;
        push        = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.eret && depth_q != 2'd0) begin
                    state_d     = RET;
                    stall_d     = 1'b1;
                    pc_load_d   = 1'b1;
                    int_end_d   = 1'b1;
                    pc_target_d = top_entry;
                    depth_d     = depth_q - 2'd1;
                end else if (pending_q || bus.int_req) begin
                    state_d   = DRAIN;
                    stall_d   = 1'b1;
                    pending_d = 1'b0;
                end
            end
            DRAIN: begin
                if (bus.pipe_empty) begin
                    if (bus.int_level == 3'b000 || depth_q == 2'(DEPTH)) begin
                        state_d = IDLE;
                        stall_d = 1'b0;
                    end else begin
                        state_d     = VEC;
                        push        = 1'b1;
                        depth_d     = depth_q + 2'd1;
                        pc_target_d = vec_addr;
                        pc_load_d   = 1'b1;
                    end
                end
            end
            VEC, RET: begin
                state_d = IDLE;
                stall_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
                stall_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            stall_q     <= 1'b0;
            pc_load_q   <= 1'b0;
            int_end_q   <= 1'b0;
            pc_target_q <= '0;
            depth_q     <= 2'd0;
            pending_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_q     <= stall_d;
            pc_load_q   <= pc_load_d;
            int_end_q   <= int_end_d;
            pc_target_q <= pc_target_d;
            depth_q     <= depth_d;
            pending_q   <= pending_d;
        end
    end

    // Stack contents need no reset; depth alone says what is valid.
    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (reset && push && depth_q == 2'(i)) stack_q[i] <= bus.pc_current;
        end
    end

`ifdef INTSEQ_ERR_EN
    logic err_set;
    logic err_q;

    assign err_set = (state_q == IDLE && bus.eret && depth_q == 2'd0) ||
                     (state_q == DRAIN && bus.pipe_empty && bus.int_level != 3'b000 &&
                      depth_q == 2'(DEPTH));

    always_ff @(posedge clock) begin
        if (!reset)       err_q <= 1'b0;
        else if (err_set) err_q <= 1'b1;
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.stall     = stall_q;
    assign bus.pc_load   = pc_load_q;
    assign bus.pc_target = pc_target_q;
    assign bus.int_end   = int_end_q;
    assign bus.depth     = depth_q;

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Sequences CPU entry into and exit from interrupt handlers, driven by the 3-level priority Interrupt block.
- On an interrupt it stalls fetch, waits for the pipeline to drain, pushes the resume PC onto a nesting stack and redirects the PC to a per-level vector.
- On ERET it pops the stack, redirects the PC back to the resume address and pulses the Interrupt block's interruptEnd.
- Sits between Interrupt (inputs interrupted/interruptOut) and the PC/fetch stage.

Parameters:
- PC_WIDTH, 32, width of PC and stack entries.
- DEPTH, 3, nesting stack entries (one per priority level).
- VECTOR_BASE, 32'h0000_0100, handler address for level index 0.
- VECTOR_STRIDE, 32'h0000_0010, address step between level vectors.

Ports:
- clock  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- int_req  in  1  one-cycle pulse from Interrupt.interrupted: a new or higher-priority interrupt is active.
- int_level  in  3  one-hot active level from Interrupt.interruptOut.
- pc_current  in  PC_WIDTH  address of next unexecuted instruction, valid when pipe_empty=1.
- pipe_empty  in  1  no instruction in flight past fetch.
- eret  in  1  one-cycle pulse, ERET instruction retiring.
- stall  out  1  hold fetch / PC.
- pc_load  out  1  one-cycle pulse: PC <= pc_target.
- pc_target  out  PC_WIDTH  redirect address, valid while pc_load=1.
- int_end  out  1  one-cycle pulse to Interrupt.interruptEnd.
- depth  out  2  current nesting depth, 0..DEPTH.
- err  out  1  sticky error flag (see Optional Feature).

Behaviour:
- Clock and reset: single clock; synchronous active-low reset (reset=0 sampled at posedge).
- Reset values: state=IDLE; stall, pc_load, int_end, err all 0; pc_target=0; depth=0; pending=0; stack contents don't-care. Reset mid-sequence aborts immediately with no push, pop or pulse.
- Outputs: all registered.
- pending flag: set by int_req in any state; cleared on entry to DRAIN. An int_req pulse is never lost.
- IDLE:
  - eret=1 and depth>0 -> RET (eret has priority over pending/int_req in the same cycle; pending is kept).
  - Else if pending or int_req -> DRAIN, stall<=1.
  - eret=1 with depth=0 -> ignored, err set.
- DRAIN: stall held at 1. In the first cycle M with pipe_empty=1:
  - int_level=000 (spurious): stall<=0 -> IDLE, no push.
  - depth==DEPTH (overflow): stall<=0 -> IDLE, no push, err set.
  - Otherwise: stack[depth]<=pc_current(M), depth<=depth+1, pc_target<=VECTOR_BASE+idx*VECTOR_STRIDE (idx = highest set bit of int_level: 100->2, 010->1, 001->0), pc_load<=1 -> VEC.
- VEC: one cycle; pc_load<=0, stall<=0 -> IDLE.
- RET: one cycle with stall=1:
  - Registered outputs at this cycle: pc_target=stack[depth-1], pc_load=1, int_end=1; depth<=depth-1.
  - Next cycle: IDLE, pc_load=0, int_end=0, stall=0.
- Latency:
  - int_req at N, pipe_empty already 1: stall=1 at N+1; pc_load at N+2; stall=0 at N+3.
  - eret at N: pc_load/int_end at N+1; stall=0 at N+2.
- Nesting: a higher-level int_req during VEC or RET is held in pending and serviced from the following IDLE. Stack is LIFO; depth never wraps.
- Width: address arithmetic truncated to PC_WIDTH.

Optional Feature:
- Macro: INTSEQ_ERR_EN.
- Defined: err is a sticky register set on ERET-at-depth-0 or stack overflow; cleared only by reset.
- Undefined: err tied to 0, error logic omitted. Ignore/drop behaviour is unchanged.

Test Plan:
- Basic entry: pipe_empty=1, pc_current=0x0000_2000, int_level=010, int_req pulse at N -> stall=1 at N+1; pc_load=1 with pc_target=0x0000_0110 at N+2; depth=1; stall=0 at N+3.
- Drain wait: pipe_empty=0 for 4 cycles after int_req, pc_current=0x3000 when it rises -> no pc_load until one cycle after pipe_empty=1; stack holds 0x3000.
- Nesting and return:
  - Level 001 at pc 0x1000, then level 100 at pc 0x0104 -> depth=2, second pc_target=0x0120.
  - eret -> pc_target=0x0104 with int_end=1, depth=1.
  - eret -> pc_target=0x1000, depth=0.
- Simultaneous eret and int_req in IDLE, depth=1 -> RET first (pop, int_end pulse); then DRAIN entered from pending; pc_load for the new vector follows.
- Errors (INTSEQ_ERR_EN defined): eret at depth=0 -> no pc_load/int_end, err=1. Fourth nested request at depth=3 -> no push, stall released, err stays 1.
- Reset mid-DRAIN: reset=0 for 1 cycle while stall=1 -> next cycle stall=0, depth=0, pc_load=0, pending=0.
